sparse_xor_sequencer: RTL and testbench

- Sequences the shifted-XOR accumulate datapath for sparse×dense cyclic polynomial multiplication over GF(2)[x]/(x^(32·N_WORDS)-1).
- Consumes sparse positions in pairs (high, low). Per pair, runs one pass over all N_WORDS accumulator words, driving dense-word addresses, start offsets and accumulator read/write.
- Dummy positions (constant-time padding) run with identical timing; their writes go to a scratch bank.

---
 rtl/sparse_xor_sequencer.sv | 167 ++++++++++++++++
 tb/tb_sparse_xor_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_xor_sequencer.sv
// Address/offset sequencer for sparse x dense cyclic multiply over GF(2)[x]/(x^(32*N_WORDS)-1).
// Optional build macro SPARSE_RANGE_CHECK_EN adds the sticky range_err flag and forces out-of-range pairs to dummy.
module sparse_xor_sequencer #(
    parameter int WORD_WIDTH = 32,
    parameter int N_WORDS    = 8,
    parameter int AW         = $clog2(N_WORDS),
    parameter int IDX_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             pair_valid,
    output logic             pair_ready,
    input  logic [IDX_W-1:0] pos_hi,
    input  logic [IDX_W-1:0] pos_lo,
    input  logic             pair_dummy,
    input  logic             pair_last,
    output logic [AW-1:0]    hi_l_addr,
    output logic [AW-1:0]    hi_r_addr,
    output logic [AW-1:0]    lo_l_addr,
    output logic [AW-1:0]    lo_r_addr,
    output logic [AW-1:0]    acc_rd_addr,
    output logic [4:0]       high_start,
    output logic [4:0]       low_start,
    output logic             acc_wr_en,
    output logic [AW-1:0]    acc_wr_addr,
    output logic             acc_wr_dummy
`ifdef SPARSE_RANGE_CHECK_EN
    ,
    output logic             range_err
`endif
);

    localparam int          OFS_W   = $clog2(WORD_WIDTH);
    localparam int unsigned NW      = N_WORDS;
    localparam int          M_ITERS = ((1 << (IDX_W - OFS_W)) / N_WORDS) + 1;
    localparam logic [AW-1:0] LAST_W = AW'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [4:0] hs_q, ls_q;
    logic       dummy_q, last_q;
    logic       accept;
    logic       pos_oor;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v);
        return (v == LAST_W) ? '0 : v + 1'b1;
    endfunction

    // Right-word index for word 0: (-(q + nz)) mod N_WORDS, reduced by bounded subtraction.
    function automatic logic [AW-1:0] base_addr(input logic [IDX_W-1:0] p);
        int unsigned m;
        m = 32'(p >> OFS_W) + 32'(p[OFS_W-1:0] != '0);
        for (int k = 0; k < M_ITERS; k++) begin
            if (m >= NW) m = m - NW;
        end
        return (m == 0) ? '0 : AW'(NW - m);
    endfunction

    function automatic logic [4:0] offset(input logic [IDX_W-1:0] p);
        return 5'(-p[OFS_W-1:0]);
    endfunction

`ifdef SPARSE_RANGE_CHECK_EN
    assign pos_oor = (32'(pos_hi) >= 32'(32 * N_WORDS)) || (32'(pos_lo) >= 32'(32 * N_WORDS));
`else
    assign pos_oor = 1'b0;
`endif

    // Pair handshake: a pair transfers on any cycle where pair_valid && pair_ready are both high;
    // pair_ready is high only in FETCH and the pair fields are sampled on that same edge.
    assign accept = (state == FETCH) && pair_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pair_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                pair_ready = 1'b1;
                if (pair_valid) state_nxt = RUN;
            end
            RUN: begin
                if (acc_rd_addr == LAST_W) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = last_q ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address counters advance on every RUN cycle except the last, so they hold outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r_addr    <= '0;
            hi_l_addr    <= '0;
            lo_r_addr    <= '0;
            lo_l_addr    <= '0;
            acc_rd_addr  <= '0;
            hs_q         <= '0;
            ls_q         <= '0;
            dummy_q      <= 1'b0;
            last_q       <= 1'b0;
            high_start   <= '0;
            low_start    <= '0;
            acc_wr_en    <= 1'b0;
            acc_wr_addr  <= '0;
            acc_wr_dummy <= 1'b0;
            done         <= 1'b0;
        end else begin
            acc_wr_en <= (state == RUN);
            done      <= (state == DRAIN) && last_q;
            if (accept) begin
                hi_r_addr   <= base_addr(pos_hi);
                hi_l_addr   <= wrap_inc(base_addr(pos_hi));
                lo_r_addr   <= base_addr(pos_lo);
                lo_l_addr   <= wrap_inc(base_addr(pos_lo));
                acc_rd_addr <= '0;
                hs_q        <= offset(pos_hi);
                ls_q        <= offset(pos_lo);
                dummy_q     <= pair_dummy | pos_oor;
                last_q      <= pair_last;
            end
            if (state == RUN) begin
                acc_wr_addr  <= acc_rd_addr;
                high_start   <= hs_q;
                low_start    <= ls_q;
                acc_wr_dummy <= dummy_q;
                if (acc_rd_addr != LAST_W) begin
                    hi_r_addr   <= wrap_inc(hi_r_addr);
                    hi_l_addr   <= wrap_inc(hi_l_addr);
                    lo_r_addr   <= wrap_inc(lo_r_addr);
                    lo_l_addr   <= wrap_inc(lo_l_addr);
                    acc_rd_addr <= acc_rd_addr + 1'b1;
                end
            end
        end
    end

`ifdef SPARSE_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          range_err <= 1'b0;
        else if (state == IDLE && start)  range_err <= 1'b0;
        else if (accept && pos_oor)       range_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sparse_xor_sequencer.sv
// Self-checking bench for sparse_xor_sequencer against a modular-arithmetic reference model.
// Build with SPARSE_RANGE_CHECK_EN defined to also exercise range_err.
module tb_sparse_xor_sequencer;
    localparam int N     = 8;
    localparam int AW    = 3;
    localparam int IDX_W = 10;
    localparam int LIMIT = 32 * N;
    localparam int RW    = AW + 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, pair_ready;
    logic             pair_valid = 1'b0;
    logic [IDX_W-1:0] pos_hi = '0;
    logic [IDX_W-1:0] pos_lo = '0;
    logic             pair_dummy = 1'b0;
    logic             pair_last = 1'b0;
    logic [AW-1:0]    hi_l_addr, hi_r_addr, lo_l_addr, lo_r_addr, acc_rd_addr, acc_wr_addr;
    logic [4:0]       high_start, low_start;
    logic             acc_wr_en, acc_wr_dummy;
`ifdef SPARSE_RANGE_CHECK_EN
    logic             range_err;
    bit               exp_rerr;
`endif

    logic [RW-1:0] exp_q[$];
    int            q_hi[$];
    int            q_lo[$];
    bit            q_dum[$];
    int            n_checks = 0;
    int            n_pass = 0;

    sparse_xor_sequencer #(.WORD_WIDTH(32), .N_WORDS(N), .AW(AW), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pos_hi(pos_hi), .pos_lo(pos_lo), .pair_dummy(pair_dummy), .pair_last(pair_last),
        .hi_l_addr(hi_l_addr), .hi_r_addr(hi_r_addr), .lo_l_addr(lo_l_addr), .lo_r_addr(lo_r_addr),
        .acc_rd_addr(acc_rd_addr), .high_start(high_start), .low_start(low_start),
        .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_dummy(acc_wr_dummy)
`ifdef SPARSE_RANGE_CHECK_EN
        , .range_err(range_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int mod_n(int v);
        return ((v % N) + N) % N;
    endfunction

    function automatic int ofs(int p);
        return (32 - (p % 32)) % 32;
    endfunction

    // Right-word index read while producing output word i.
    function automatic int rword(int p, int i);
        return mod_n(i - p / 32 - (((p % 32) != 0) ? 1 : 0));
    endfunction

    task automatic clear_pairs();
        q_hi.delete();
        q_lo.delete();
        q_dum.delete();
    endtask

    task automatic add_pair(input int hi, input int lo, input bit dum);
        q_hi.push_back(hi);
        q_lo.push_back(lo);
        q_dum.push_back(dum);
    endtask

    // Runs one multiplication over the queued pairs, checking every cycle; gap idles FETCH between pairs.
    task automatic drive_mult(input int gap);
        int            n;
        int            hi, lo;
        bit            eff_dum;
        logic [RW-1:0] exp_w;
        logic [5*AW-1:0] exp_a;
        n = q_hi.size();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({busy, pair_ready, done} !== 3'b110)
            $display("FAIL start_accept: got %b exp 110", {busy, pair_ready, done});
        else n_pass++;
`ifdef SPARSE_RANGE_CHECK_EN
        exp_rerr = 1'b0;
        n_checks++;
        if (range_err !== exp_rerr) $display("FAIL range_clear: got %b exp %b", range_err, exp_rerr);
        else n_pass++;
`endif
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    n_checks++;
                    if ({pair_ready, busy, acc_wr_en} !== 3'b110)
                        $display("FAIL stall: got %b exp 110", {pair_ready, busy, acc_wr_en});
                    else n_pass++;
                    step();
                end
            end
            hi = q_hi[k];
            lo = q_lo[k];
            eff_dum = q_dum[k];
`ifdef SPARSE_RANGE_CHECK_EN
            if (hi >= LIMIT || lo >= LIMIT) begin
                eff_dum = 1'b1;
                exp_rerr = 1'b1;
            end
`endif
            pair_valid = 1'b1;
            pos_hi = IDX_W'(hi);
            pos_lo = IDX_W'(lo);
            pair_dummy = q_dum[k];
            pair_last = (k == n - 1);
            for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), 5'(ofs(hi)), 5'(ofs(lo)), eff_dum});
            step();
            pair_valid = 1'b0;
            pos_hi = IDX_W'($urandom);
            pos_lo = IDX_W'($urandom);
            pair_dummy = ~pair_dummy;
            pair_last = ~pair_last;
`ifdef SPARSE_RANGE_CHECK_EN
            n_checks++;
            if (range_err !== exp_rerr) $display("FAIL range_err: got %b exp %b", range_err, exp_rerr);
            else n_pass++;
`endif
            for (int i = 0; i <= N; i++) begin
                if (i < N) begin
                    exp_a = {AW'(rword(hi, i)), AW'(mod_n(rword(hi, i) + 1)),
                             AW'(rword(lo, i)), AW'(mod_n(rword(lo, i) + 1)), AW'(i)};
                    n_checks++;
                    if ({hi_r_addr, hi_l_addr, lo_r_addr, lo_l_addr, acc_rd_addr} !== exp_a)
                        $display("FAIL addr word %0d: got %h exp %h", i,
                                 {hi_r_addr, hi_l_addr, lo_r_addr, lo_l_addr, acc_rd_addr}, exp_a);
                    else n_pass++;
                end
                if (i == 0) begin
                    n_checks++;
                    if (acc_wr_en !== 1'b0) $display("FAIL wr_en_run0: got %b exp 0", acc_wr_en);
                    else n_pass++;
                end else begin
                    exp_w = exp_q.pop_front();
                    n_checks++;
                    if ({acc_wr_en, acc_wr_addr, high_start, low_start, acc_wr_dummy} !== {1'b1, exp_w})
                        $display("FAIL write %0d: got %h exp %h", i - 1,
                                 {acc_wr_en, acc_wr_addr, high_start, low_start, acc_wr_dummy}, {1'b1, exp_w});
                    else n_pass++;
                end
                step();
            end
            if (k == n - 1) begin
                n_checks++;
                if ({done, busy, acc_wr_en} !== 3'b100)
                    $display("FAIL done_pulse: got %b exp 100", {done, busy, acc_wr_en});
                else n_pass++;
            end else begin
                n_checks++;
                if ({done, busy, pair_ready, acc_wr_en} !== 4'b0110)
                    $display("FAIL next_fetch: got %b exp 0110", {done, busy, pair_ready, acc_wr_en});
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL write_count: got %0d left exp 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
        step();
        n_checks++;
        if ({done, busy, acc_wr_en} !== 3'b000)
            $display("FAIL after_done: got %b exp 000", {done, busy, acc_wr_en});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({busy, done, pair_ready, hi_l_addr, hi_r_addr, lo_l_addr, lo_r_addr, acc_rd_addr,
             high_start, low_start, acc_wr_en, acc_wr_addr, acc_wr_dummy} !== '0)
            $display("FAIL reset_outputs: got nonzero exp 0");
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if ({busy, pair_ready, acc_wr_en, done} !== 4'b0000)
            $display("FAIL idle_after_reset: got %b exp 0000", {busy, pair_ready, acc_wr_en, done});
        else n_pass++;
    endtask

    task automatic test_basic_pair();
        logic [5*AW-1:0] exp_a;
        clear_pairs();
        add_pair(0, 33, 1'b0);
        drive_mult(0);
        exp_a = {AW'(rword(0, N - 1)), AW'(mod_n(rword(0, N - 1) + 1)),
                 AW'(rword(33, N - 1)), AW'(mod_n(rword(33, N - 1) + 1)), AW'(N - 1)};
        n_checks++;
        if ({hi_r_addr, hi_l_addr, lo_r_addr, lo_l_addr, acc_rd_addr} !== exp_a)
            $display("FAIL addr_hold: got %h exp %h", {hi_r_addr, hi_l_addr, lo_r_addr, lo_l_addr, acc_rd_addr}, exp_a);
        else n_pass++;
    endtask

    task automatic test_zero_shift();
        clear_pairs();
        add_pair(32, 64, 1'b0);
        drive_mult(0);
    endtask

    task automatic test_dummy_middle();
        clear_pairs();
        add_pair(7, 100, 1'b0);
        add_pair(200, 5, 1'b1);
        add_pair(255, 0, 1'b0);
        drive_mult(0);
    endtask

    task automatic test_stall();
        clear_pairs();
        add_pair(1, 31, 1'b0);
        add_pair(130, 250, 1'b0);
        drive_mult(5);
    endtask

    task automatic test_back_to_back();
        int np;
        for (int m = 0; m < 6; m++) begin
            clear_pairs();
            np = $urandom_range(1, 4);
            for (int k = 0; k < np; k++)
                add_pair($urandom_range(0, LIMIT - 1), $urandom_range(0, LIMIT - 1), 1'($urandom_range(0, 1)));
            drive_mult($urandom_range(0, 2));
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        pos_hi = 10'd5;
        pos_lo = 10'd77;
        pair_dummy = 1'b0;
        pair_last = 1'b1;
        pair_valid = 1'b1;
        step();
        pair_valid = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if ({acc_rd_addr, acc_wr_en, acc_wr_addr} !== {AW'(3), 1'b1, AW'(2)})
            $display("FAIL run_word3: got %h exp %h", {acc_rd_addr, acc_wr_en, acc_wr_addr}, {AW'(3), 1'b1, AW'(2)});
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, pair_ready, hi_l_addr, hi_r_addr, lo_l_addr, lo_r_addr, acc_rd_addr,
             high_start, low_start, acc_wr_en, acc_wr_addr, acc_wr_dummy} !== '0)
            $display("FAIL mid_reset_outputs: got nonzero exp 0");
        else n_pass++;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({acc_wr_en, busy, done} !== 3'b000)
                $display("FAIL post_reset_quiet: got %b exp 000", {acc_wr_en, busy, done});
            else n_pass++;
        end
        clear_pairs();
        add_pair(5, 77, 1'b0);
        drive_mult(0);
    endtask

`ifdef SPARSE_RANGE_CHECK_EN
    task automatic test_range_check();
        clear_pairs();
        add_pair(10, 300, 1'b0);
        drive_mult(0);
        n_checks++;
        if (range_err !== 1'b1) $display("FAIL range_sticky: got %b exp 1", range_err);
        else n_pass++;
        clear_pairs();
        add_pair(40, 41, 1'b0);
        drive_mult(0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pair();
        test_zero_shift();
        test_dummy_middle();
        test_stall();
        test_back_to_back();
        test_mid_reset();
`ifdef SPARSE_RANGE_CHECK_EN
        test_range_check();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
